// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide path.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int STEP_COUNT    = DEFAULT_WIDTH;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into hi, then
// arithmetic shift right of {hi, lo, q_1}.
module booth_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  input  logic               q_1,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH:0]   prod_next
);

  logic [WIDTH:0] hi_ext;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  assign hi_ext = {hi[WIDTH-1], hi};
  assign m_ext  = {m[WIDTH-1], m};

  // One guard bit keeps M = -2^(WIDTH-1) exact when it is subtracted.
  always_comb begin
    sum = hi_ext;
    case ({lo[0], q_1})
      2'b01:   sum = hi_ext + m_ext;
      2'b10:   sum = hi_ext - m_ext;
      default: sum = hi_ext;
    endcase
  end

  // Shifting {sum, lo, q_1} right by one leaves exactly {sum, lo}.
  assign prod_next = {sum, lo};

endmodule

// File: rtl/booth_mult32.sv
// Sequential radix-2 Booth multiplier: load on ctrl_mult, 32 steps, one-cycle
// result_rdy pulse with the low product word and an overflow flag.
module booth_mult32
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  m_q;
  logic [2*WIDTH:0]  prod_q;
  logic [2*WIDTH:0]  prod_d;
  logic              rdy_q;
  logic              busy_q;
  logic              last_step;

  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  assign hi = prod_q[2*WIDTH:WIDTH+1];
  assign lo = prod_q[WIDTH:1];

  booth_step #(.WIDTH(WIDTH)) u_step (
    .hi        (hi),
    .lo        (lo),
    .q_1       (prod_q[0]),
    .m         (m_q),
    .prod_next (prod_d)
  );

  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      prod_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      // A strobe wins in every state, silently dropping any operation in flight.
      if (ctrl_mult) begin
        m_q     <= operand_a;
        prod_q  <= {{WIDTH{1'b0}}, operand_b, 1'b0};
        cnt_q   <= '0;
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + 1'b1;
            if (last_step) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign result     = lo;
  assign exception  = (hi != {WIDTH{lo[WIDTH-1]}});
  assign result_rdy = rdy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_booth_mult32.sv
// Directed bench for booth_mult32 with a queue scoreboard of reference products.
module tb_booth_mult32;

  typedef struct {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        ctrl_mult = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] result;
  logic        exception;
  logic        result_rdy;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t sb[$];

  logic [31:0] got_res;
  logic        got_exc;
  int          pulses;
  int          rdy_k;

  always #5 clk = ~clk;

  booth_mult32 dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .ctrl_mult  (ctrl_mult),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .result     (result),
    .exception  (exception),
    .result_rdy (result_rdy),
    .busy       (busy)
  );

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    e.res = p[31:0];
    e.exc = (p != {{32{p[31]}}, p[31:0]});
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe sampled at the next rising edge; returns #1 after that edge.
  task automatic strobe(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ctrl_mult = 1'b1;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    ctrl_mult = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  // Watches up to 'budget' edges after a strobe, scoring every rdy pulse.
  task automatic watch(input string tag, input int budget, output int first_k,
                       output int n_pulse, output int busy_cnt);
    exp_t e;
    first_k  = -1;
    n_pulse  = 0;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (result_rdy) begin
        n_pulse++;
        if (first_k < 0) begin
          first_k = k;
          got_res = result;
          got_exc = exception;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_result"}, {32'h0, result}, {32'h0, e.res});
            chk({tag, "_exception"}, {63'h0, exception}, {63'h0, e.exc});
          end else begin
            chk({tag, "_unexpected_rdy"}, 64'd1, 64'd0);
          end
        end
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int busy_cnt;
    sb.push_back(model(a, b));
    strobe(a, b);
    watch(tag, 40, rdy_k, pulses, busy_cnt);
    chk({tag, "_rdy_latency"}, 64'(rdy_k), 64'd32);
    chk({tag, "_rdy_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    chk({tag, "_idle_hold"}, {32'h0, result}, {32'h0, got_res});
    $display("op %s: %h * %h -> result=%h exception=%0d rdy_at=%0d",
             tag, a, b, got_res, got_exc, rdy_k);
  endtask

  initial begin
    int busy_cnt;
    int seen;

    // Reset held with random inputs
    clr_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctrl_mult = 1'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
    end
    #1;
    chk("reset_result", {32'h0, result}, 64'h0);
    chk("reset_exception", {63'h0, exception}, 64'h0);
    chk("reset_rdy", {63'h0, result_rdy}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    ctrl_mult = 1'b0;
    clr_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (busy || result_rdy || result != 32'h0) seen++;
    end
    chk("idle_no_activity", 64'(seen), 64'd0);

    do_op("mul_7_m3", 32'h0000_0007, 32'hFFFF_FFFD);
    chk("mul_7_m3_const", {31'h0, got_exc, got_res}, {31'h0, 1'b0, 32'hFFFF_FFEB});
    do_op("mul_min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
    chk("mul_min_m1_const", {31'h0, got_exc, got_res}, {31'h0, 1'b1, 32'h8000_0000});
    do_op("mul_2p16_sq", 32'h0001_0000, 32'h0001_0000);
    chk("mul_2p16_sq_const", {31'h0, got_exc, got_res}, {31'h0, 1'b1, 32'h0000_0000});
    do_op("mul_max_1", 32'h7FFF_FFFF, 32'h0000_0001);
    chk("mul_max_1_const", {31'h0, got_exc, got_res}, {31'h0, 1'b0, 32'h7FFF_FFFF});
    do_op("mul_rand", $urandom, $urandom);

    // Restart at step 10: the first operation is abandoned
    sb.push_back(model(32'd5, 32'd5));
    strobe(32'd5, 32'd5);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    void'(sb.pop_back());
    sb.push_back(model(32'd6, 32'd7));
    strobe(32'd6, 32'd7);
    watch("restart", 45, rdy_k, pulses, busy_cnt);
    chk("restart_rdy_latency", 64'(rdy_k), 64'd32);
    chk("restart_rdy_pulses", 64'(pulses), 64'd1);
    chk("restart_result_const", {32'h0, got_res}, 64'd42);
    $display("op restart: 6 * 7 -> result=%h rdy_at=%0d pulses=%0d", got_res, rdy_k, pulses);

    // Asynchronous reset at step 15
    sb.push_back(model(32'h1234_5678, 32'h0000_0100));
    strobe(32'h1234_5678, 32'h0000_0100);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    clr_n = 1'b0;
    #1;
    chk("midreset_busy", {63'h0, busy}, 64'h0);
    chk("midreset_rdy", {63'h0, result_rdy}, 64'h0);
    chk("midreset_result", {32'h0, result}, 64'h0);
    sb.delete();
    @(negedge clk);
    clr_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (result_rdy || busy) seen++;
    end
    chk("midreset_no_rdy", 64'(seen), 64'd0);
    $display("op midreset: busy=%0d rdy_events_after=%0d", busy, seen);

    do_op("mul_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul_m1_m1_const", {31'h0, got_exc, got_res}, {31'h0, 1'b0, 32'h0000_0001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
